// File: rtl/magnitude_est_pipe_pkg.sv
// Shared definitions for the streaming I/Q magnitude estimator.
package magnitude_est_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_3_8   = 2'd0,
    MODE_1_2   = 2'd1,
    MODE_1_4   = 2'd2,
    MODE_15_16 = 2'd3
  } mag_mode_e;

  localparam int MAG_LATENCY = 3;

endpackage

// File: rtl/mag_coef_sum.sv
// Alpha-max/beta-min weighted sum of A (max) and B (min), saturated to DATA_WIDTH.
// Combinational; no handshake.
module mag_coef_sum
  import magnitude_est_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  mag_mode_e             mode,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int SW = DATA_WIDTH + 2;

  logic [SW-1:0] a_x;
  logic [SW-1:0] b_x;
  logic [SW-1:0] sum;

  assign a_x = SW'(a);
  assign b_x = SW'(b);

  // Two guard bits hold the 3B term and any carry before saturation.
  always_comb begin
    sum = '0;
    case (mode)
      MODE_3_8: sum = a_x + ((b_x + (b_x << 1)) >> 3);
      MODE_1_2: sum = a_x + (b_x >> 1);
      MODE_1_4: sum = a_x + (b_x >> 2);
      default:  sum = (a_x - (a_x >> 4)) + ((b_x >> 1) - (b_x >> 5));
    endcase
    result = (sum[SW-1:DATA_WIDTH] != '0) ? '1 : sum[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/magnitude_est_pipe.sv
// Streaming |I+jQ| estimator with peak hold; 3-cycle latency, 1 sample/cycle.
// Global stall: all stages freeze while out_valid & !out_ready, in_ready follows.
module magnitude_est_pipe
  import magnitude_est_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic signed [DATA_WIDTH-1:0] q_data,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        magnitude,
  output logic [TAG_WIDTH-1:0]         out_tag,
  input  logic                         peak_clr,
  output logic [DATA_WIDTH-1:0]        peak_mag
);

  logic                  advance;
  logic [DATA_WIDTH-1:0] abs_i;
  logic [DATA_WIDTH-1:0] abs_q;
  logic [DATA_WIDTH-1:0] coef_res;

  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_abs_i;
  logic [DATA_WIDTH-1:0] s1_abs_q;
  mag_mode_e             s1_mode;
  logic [TAG_WIDTH-1:0]  s1_tag;

  logic                  s2_vld;
  logic [DATA_WIDTH-1:0] s2_a;
  logic [DATA_WIDTH-1:0] s2_b;
  mag_mode_e             s2_mode;
  logic [TAG_WIDTH-1:0]  s2_tag;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Negating the most negative value leaves 2^(W-1), which is exact when read unsigned.
  assign abs_i = i_data[DATA_WIDTH-1] ? $unsigned(-i_data) : $unsigned(i_data);
  assign abs_q = q_data[DATA_WIDTH-1] ? $unsigned(-q_data) : $unsigned(q_data);

  mag_coef_sum #(.DATA_WIDTH(DATA_WIDTH)) u_coef (
    .a      (s2_a),
    .b      (s2_b),
    .mode   (s2_mode),
    .result (coef_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_abs_i  <= '0;
      s1_abs_q  <= '0;
      s1_mode   <= MODE_3_8;
      s1_tag    <= '0;
      s2_vld    <= 1'b0;
      s2_a      <= '0;
      s2_b      <= '0;
      s2_mode   <= MODE_3_8;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      magnitude <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      s1_vld    <= in_valid;
      s2_vld    <= s1_vld;
      out_valid <= s2_vld;
      if (in_valid) begin
        s1_abs_i <= abs_i;
        s1_abs_q <= abs_q;
        s1_mode  <= mag_mode_e'(mode);
        s1_tag   <= in_tag;
      end
      if (s1_vld) begin
        s2_a    <= (s1_abs_i >= s1_abs_q) ? s1_abs_i : s1_abs_q;
        s2_b    <= (s1_abs_i >= s1_abs_q) ? s1_abs_q : s1_abs_i;
        s2_mode <= s1_mode;
        s2_tag  <= s1_tag;
      end
      if (s2_vld) begin
        magnitude <= coef_res;
        out_tag   <= s2_tag;
      end
    end
  end

  // An accepted output wins over a simultaneous clear so that sample is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_mag <= '0;
    end else if (out_valid && out_ready && (peak_clr || (magnitude > peak_mag))) begin
      peak_mag <= magnitude;
    end else if (peak_clr) begin
      peak_mag <= '0;
    end
  end

endmodule

// File: tb/tb_magnitude_est_pipe.sv
// Directed self-checking bench for magnitude_est_pipe.
module tb_magnitude_est_pipe;
  import magnitude_est_pipe_pkg::*;

  localparam int DW = 16;
  localparam int TW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0]           mode = 2'd0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] i_data = '0;
  logic signed [DW-1:0] q_data = '0;
  logic [TW-1:0]        in_tag = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DW-1:0]        magnitude;
  logic [TW-1:0]        out_tag;
  logic                 peak_clr = 1'b0;
  logic [DW-1:0]        peak_mag;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_m[4] = '{5125, 5500, 4750, 5157};

  magnitude_est_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_data    (i_data),
    .q_data    (q_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .magnitude (magnitude),
    .out_tag   (out_tag),
    .peak_clr  (peak_clr),
    .peak_mag  (peak_mag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input int q, input int m, input int t);
    i_data   = DW'(i);
    q_data   = DW'(q);
    mode     = 2'(m);
    in_tag   = TW'(t);
    in_valid = 1'b1;
  endtask

  // One isolated sample; checks the exact cycle out_valid rises.
  task automatic run_one(input string tag, input int i, input int q, input int m,
                         input int t, input int exp);
    @(negedge clk);
    drive(i, q, m, t);
    chk($sformatf("%s.rdy", tag), 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k < MAG_LATENCY; k++) begin
      chk($sformatf("%s.early%0d", tag, k), 32'(out_valid), 0);
      @(negedge clk);
    end
    chk($sformatf("%s.vld", tag), 32'(out_valid), 1);
    chk($sformatf("%s.mag", tag), 32'(magnitude), 32'(exp));
    chk($sformatf("%s.tag", tag), 32'(out_tag), 32'(t));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.vld", 32'(out_valid), 0);
    chk("rst.mag", 32'(magnitude), 0);
    chk("rst.tag", 32'(out_tag), 0);
    chk("rst.peak", 32'(peak_mag), 0);
    rst_n = 1'b1;
    #1 chk("rst.rdy", 32'(in_ready), 1);

    // Coefficient modes on (3000, -4000) and the reverse ordering
    run_one("m0", 3000, -4000, 0, 5, 5125);
    run_one("m1", 3000, -4000, 1, 5, 5500);
    run_one("m2", 3000, -4000, 2, 5, 4750);
    run_one("m3", 3000, -4000, 3, 5, 5157);
    run_one("m3swap", -4000, 3000, 3, 6, 5157);

    // Most negative inputs: no wrap, no false saturation
    run_one("x1", -32768, -32768, 1, 1, 49152);
    run_one("x0", -32768, -32768, 0, 2, 45056);
    run_one("x2", -32768, -32768, 2, 3, 40960);
    run_one("x3", -32768, -32768, 3, 4, 46080);
    @(negedge clk);
    chk("x.peak", 32'(peak_mag), 49152);

    // Back-to-back stream, mode changing every sample
    for (int c = 0; c < 12; c++) begin
      if (c >= 3 && c < 11) begin
        chk($sformatf("st%0d.vld", c - 3), 32'(out_valid), 1);
        chk($sformatf("st%0d.mag", c - 3), 32'(magnitude), 32'(exp_m[(c - 3) % 4]));
        chk($sformatf("st%0d.tag", c - 3), 32'(out_tag), 32'(c - 3));
      end
      if (c == 11) chk("st.drain", 32'(out_valid), 0);
      if (c < 8) drive(3000, -4000, c % 4, c);
      else in_valid = 1'b0;
      @(negedge clk);
    end

    // Backpressure with a full pipeline
    drive(3000, -4000, 0, 8);
    @(negedge clk);
    drive(3000, -4000, 1, 9);
    @(negedge clk);
    drive(3000, -4000, 2, 10);
    @(negedge clk);
    chk("bp.first", 32'(out_tag), 8);
    out_ready = 1'b0;
    drive(3000, -4000, 3, 11);
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp.rdy%0d", k), 32'(in_ready), 0);
      chk($sformatf("bp.vld%0d", k), 32'(out_valid), 1);
      chk($sformatf("bp.mag%0d", k), 32'(magnitude), 5125);
      chk($sformatf("bp.tag%0d", k), 32'(out_tag), 8);
    end
    out_ready = 1'b1;
    #1 chk("bp.release", 32'(in_ready), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("bp.out%0d.vld", k), 32'(out_valid), 1);
      chk($sformatf("bp.out%0d.tag", k), 32'(out_tag), 32'(9 + k));
      chk($sformatf("bp.out%0d.mag", k), 32'(magnitude), 32'(exp_m[k + 1]));
    end
    @(negedge clk);
    chk("bp.nodup", 32'(out_valid), 0);

    // Peak hold: 100, 900, 400 (A-only inputs)
    drive(100, 0, 0, 1);
    @(negedge clk);
    drive(900, 0, 0, 2);
    @(negedge clk);
    drive(-400, 0, 0, 3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pk.900", 32'(peak_mag), 49152);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    chk("pk.clr0", 32'(peak_mag), 0);
    drive(100, 0, 0, 1);
    @(negedge clk);
    drive(900, 0, 0, 2);
    @(negedge clk);
    drive(-400, 0, 0, 3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pk.max", 32'(peak_mag), 900);

    // Clear coincident with acceptance of 250
    run_one("pk250", 0, 250, 0, 7, 250);
    chk("pk.pre", 32'(peak_mag), 900);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    chk("pk.coinc", 32'(peak_mag), 250);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    chk("pk.clr", 32'(peak_mag), 0);

    // Reset with samples in flight
    for (int k = 0; k < 4; k++) begin
      drive(3000, -4000, 1, k + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mr.peak", 32'(peak_mag), 5500);
    chk("mr.vld", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mr.vld0", 32'(out_valid), 0);
    chk("mr.peak0", 32'(peak_mag), 0);
    chk("mr.mag0", 32'(magnitude), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("mr.stale%0d", k), 32'(out_valid), 0);
    end
    chk("mr.peak_end", 32'(peak_mag), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/magnitude_est_pipe.md
Name: magnitude_est_pipe

Overview:
- Pipelined, streaming successor to the combinational max/min magnitude estimator used on the I/Q path.
- Adds:
  - clock and async reset
  - valid/ready handshake with backpressure
  - four run-time selectable alpha-max/beta-min coefficient modes
  - a sideband tag carried alongside each sample
  - a peak-hold register with its own clear input
- Sits between the complex baseband sample stream and the detection/AGC logic.

Parameters:
- DATA_WIDTH, 16: width of signed I/Q inputs and unsigned magnitude output.
- TAG_WIDTH, 4: width of the sideband tag carried with each sample (channel/index).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- mode  in  2  coefficient select, sampled with each accepted input
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- i_data  in  DATA_WIDTH  signed I component
- q_data  in  DATA_WIDTH  signed Q component
- in_tag  in  TAG_WIDTH  sideband tag
- out_valid  out  1  magnitude valid
- out_ready  in  1  downstream accepts magnitude
- magnitude  out  DATA_WIDTH  unsigned magnitude estimate
- out_tag  out  TAG_WIDTH  tag of the sample on magnitude
- peak_clr  in  1  synchronous clear of peak hold
- peak_mag  out  DATA_WIDTH  largest magnitude accepted since the last clear or reset

Behaviour:
- Reset (rst_n low, async): all stage valids 0, out_valid 0, magnitude 0, out_tag 0, peak_mag 0. in_ready is 1 after reset.
- Reset mid-operation: in-flight samples are discarded. No output is produced for them after release.
- Pipeline is 3 stages with a global stall:
  - advance = !out_valid | out_ready
  - in_ready = advance
  - Input is accepted when in_valid & in_ready.
  - Latency is 3 cycles from acceptance to out_valid when not stalled. Throughput is 1 sample/cycle.
- Stall: while out_valid & !out_ready, every stage register, magnitude and out_tag hold their values. Bubbles are not squeezed out.
- Stage 1:
  - abs_i = |i_data|, abs_q = |q_data| as unsigned DATA_WIDTH.
  - The most negative input maps to 2^(DATA_WIDTH-1) with no wrap.
  - Latch mode and in_tag.
- Stage 2:
  - A = max(abs_i, abs_q), B = min(abs_i, abs_q). On a tie, A = B = abs_i.
- Stage 3: sum in DATA_WIDTH+2 bits. Every shift truncates toward zero.
  - mode 0: A + (3B >> 3)
  - mode 1: A + (B >> 1)
  - mode 2: A + (B >> 2)
  - mode 3: (A - (A >> 4)) + ((B >> 1) - (B >> 5))
- Saturation: if the sum exceeds 2^DATA_WIDTH - 1, magnitude = all ones. For signed inputs this cannot occur, but the guard is still required.
- mode is per-sample. Changing mode affects only samples accepted on or after that cycle.
- Peak hold:
  - On out_valid & out_ready, if magnitude > peak_mag, then peak_mag <= magnitude.
  - peak_clr sets peak_mag to 0 next cycle.
  - If peak_clr coincides with an output acceptance, peak_mag <= the accepted magnitude.

Decomposition:
- Shared package holds:
  - mode encodings MODE_3_8 = 0, MODE_1_2 = 1, MODE_1_4 = 2, MODE_15_16 = 3
  - the stage-count constant MAG_LATENCY = 3
- One sub-module, mag_coef_sum: combinational A/B/mode to saturated DATA_WIDTH result, used in stage 3.

Test Plan:
- Reset, then i=3000, q=-4000, tag=5, out_ready=1:
  - mode 0 -> magnitude 5125, out_tag 5, exactly 3 cycles after acceptance
  - mode 1 -> 5500
  - mode 2 -> 4750
  - mode 3 -> 5157
- Extreme input i=-32768, q=-32768:
  - mode 1 -> 49152
  - mode 0 -> 45056
  - No wrap; saturation never falsely asserted.
- Back-to-back stream of 8 samples with mode toggling every sample -> 8 outputs in order, each using its own latched mode, tags 0..7 preserved.
- Backpressure: hold out_ready=0 for 5 cycles with the pipeline full -> in_ready=0, magnitude/out_tag stable. On release, outputs continue with none lost or duplicated.
- Peak hold:
  - Outputs 100, 900, 400 -> peak_mag 900.
  - peak_clr alone -> 0.
  - peak_clr coincident with accepting 250 -> 250.
- Assert rst_n low while 3 samples are in flight -> out_valid 0 and peak_mag 0 immediately; after release, no stale outputs appear.
